uart_txrx_core: RTL and testbench

- Full-duplex 8-bit UART: transmitter, receiver and a shared baud-tick generator in one block.
- Configurable parity (none/odd/even) and 1 or 2 stop bits; LSB-first framing.
- Sits between a register/CPU interface and the serial pins; the tx and rx lines are the only asynchronous-facing signals.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_txrx_core.sv | 199 +++++++++++++++++++
 tb/tb_uart_txrx_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, FSM state types and data width for the uart core
package uart_pkg;
    localparam int DATA_W = 8;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // 2'b11 is treated as no parity, same as PAR_NONE
    function automatic logic par_en(input logic [1:0] cfg);
        return (cfg == PAR_ODD) || (cfg == PAR_EVEN);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - modulo-BAUD_DIV counter with enable, sync clear and wrap tick
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4,
    parameter int CNT_W    = $clog2(BAUD_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] count
);
    assign tick = en && (count == CNT_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_txrx_core.sv
// rtl/uart_txrx_core.sv - full-duplex 8-bit uart; UART_LOOPBACK_EN adds loopback_i (rx fed from tx_o)
module uart_txrx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop_cfg_i,
    input  logic [1:0]        parity_cfg_i,
    input  logic              tx_en_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_o,
    output logic              tx_busy_o,
    input  logic              rx_en_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_parity_err_o,
    output logic              rx_frame_err_o
`ifdef UART_LOOPBACK_EN
    ,
    input  logic              loopback_i
`endif
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic             tx_tick;
    logic [CNT_W-1:0] tx_count_unused;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .tick  (tx_tick),
        .count (tx_count_unused)
    );

    tx_state_t         tx_state, tx_next;
    logic [DATA_W-1:0] tx_data_q;
    logic [1:0]        tx_par_q;
    logic              tx_stop2_q, tx_stop_cnt, tx_stop_done, tx_line;
    logic [BIT_W-1:0]  tx_bit, tx_bit_nx;

    assign tx_stop_done = !tx_stop2_q || tx_stop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        if (tx_tick) begin
            case (tx_state)
                TX_IDLE:   if (tx_en_i) tx_next = TX_START;
                TX_START:  tx_next = TX_DATA;
                TX_DATA:   if (tx_bit == LAST_BIT) tx_next = par_en(tx_par_q) ? TX_PARITY : TX_STOP;
                TX_PARITY: tx_next = TX_STOP;
                TX_STOP:   if (tx_stop_done) tx_next = tx_en_i ? TX_START : TX_IDLE;
                default:   tx_next = TX_IDLE;
            endcase
        end
    end

    // tx_line is the value tx_o takes at the coming tick, chosen by the state being entered
    always_comb begin
        tx_busy_o = (tx_state != TX_IDLE);
        tx_bit_nx = (tx_state == TX_DATA) ? tx_bit + 1'b1 : '0;
        case (tx_next)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_data_q[tx_bit_nx];
            TX_PARITY: tx_line = (tx_par_q == PAR_ODD) ? ~^tx_data_q : ^tx_data_q;
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_o        <= 1'b1;
            tx_data_q   <= '0;
            tx_par_q    <= PAR_NONE;
            tx_stop2_q  <= 1'b0;
            tx_stop_cnt <= 1'b0;
            tx_bit      <= '0;
        end else if (tx_tick) begin
            tx_o        <= tx_line;
            tx_bit      <= tx_bit_nx;
            tx_stop_cnt <= (tx_state == TX_STOP) && !tx_stop_done;
            if (tx_next == TX_START) begin
                tx_data_q  <= tx_data_i;
                tx_par_q   <= parity_cfg_i;
                tx_stop2_q <= stop_cfg_i;
            end
        end
    end

    logic             rx_meta, rx_sync, rx_prev, rx_line, rx_fall;
    logic             rx_run, rx_half, rx_clr, rx_tick, rx_done, rx_perr, rx_par_bit;
    logic [CNT_W-1:0] rx_count;
    rx_state_t         rx_state, rx_next;
    logic [1:0]        rx_par_q;
    logic [DATA_W-1:0] rx_shift;
    logic [BIT_W-1:0]  rx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_line;
        end
    end

`ifdef UART_LOOPBACK_EN
    assign rx_line = loopback_i ? tx_o : rx_sync;
`else
    assign rx_line = rx_sync;
`endif

    // rx bit timer is held at zero while idle and re-zeroed at the mid-start sample
    assign rx_fall = rx_prev && !rx_line;
    assign rx_run  = (rx_state != RX_IDLE);
    assign rx_half = (rx_state == RX_START) && (rx_count == CNT_W'(BAUD_DIV / 2 - 1));
    assign rx_clr  = !rx_run || rx_half;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rx_run),
        .clr   (rx_clr),
        .tick  (rx_tick),
        .count (rx_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (!rx_en_i) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:   if (rx_fall) rx_next = RX_START;
                RX_START:  if (rx_half) rx_next = rx_line ? RX_IDLE : RX_DATA;
                RX_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_next = par_en(rx_par_q) ? RX_PARITY : RX_STOP;
                RX_PARITY: if (rx_tick) rx_next = RX_STOP;
                RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_done = rx_en_i && (rx_state == RX_STOP) && rx_tick;
        case (rx_par_q)
            PAR_ODD:  rx_perr = ~(^rx_shift ^ rx_par_bit);
            PAR_EVEN: rx_perr = ^rx_shift ^ rx_par_bit;
            default:  rx_perr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_par_q        <= PAR_NONE;
            rx_shift        <= '0;
            rx_bit          <= '0;
            rx_par_bit      <= 1'b0;
            rx_data_o       <= '0;
            rx_valid_o      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
        end else begin
            rx_valid_o <= rx_done;
            if (rx_state == RX_IDLE && rx_next == RX_START) rx_par_q <= parity_cfg_i;
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_line, rx_shift[DATA_W-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == RX_PARITY && rx_tick) rx_par_bit <= rx_line;
            if (rx_done) begin
                rx_data_o       <= rx_shift;
                rx_parity_err_o <= rx_perr;
                rx_frame_err_o  <= !rx_line;
            end
        end
    end
endmodule

// File: tb/tb_uart_txrx_core.sv
// tb/tb_uart_txrx_core.sv - randomized scoreboard bench for uart_txrx_core
module tb_uart_txrx_core;
    localparam int BAUD_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stop_cfg = 1'b0;
    logic [1:0] par_cfg = 2'b00;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_o, tx_busy;
    logic       rx_en = 1'b0;
    logic       rx_i;
    logic [7:0] rx_data;
    logic       rx_valid, rx_perr, rx_ferr;
    logic       rx_sel = 1'b1;
    logic       rx_drv = 1'b1;
`ifdef UART_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    assign rx_i = rx_sel ? tx_o : rx_drv;

    uart_txrx_core #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stop_cfg_i      (stop_cfg),
        .parity_cfg_i    (par_cfg),
        .tx_en_i         (tx_en),
        .tx_data_i       (tx_data),
        .tx_o            (tx_o),
        .tx_busy_o       (tx_busy),
        .rx_en_i         (rx_en),
        .rx_i            (rx_i),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_parity_err_o (rx_perr),
        .rx_frame_err_o  (rx_ferr)
`ifdef UART_LOOPBACK_EN
        ,
        .loopback_i      (loopback)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_valid = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (tx_busy) busy_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got data %0h pe %0b fe %0b, expected no frame", rx_data, rx_perr, rx_ferr);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_frame", {22'd0, rx_data, rx_perr, rx_ferr}, {22'd0, mon_e.d, mon_e.pe, mon_e.fe});
            end
        end
    end

    // Reference: parity bit makes the total count of ones odd (odd) or even (even)
    function automatic logic par_bit(input logic [7:0] d, input logic [1:0] p);
        int ones;
        ones = $countones(d);
        return (p == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic int build_frame(input logic [7:0] d, input logic [1:0] p, input logic s2,
                                       output logic [11:0] bits);
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (p == 2'b01 || p == 2'b10) begin
            bits[n] = par_bit(d, p);
            n++;
        end
        n = n + (s2 ? 2 : 1);
        return n;
    endfunction

    task automatic wait_tx_fall(output logic ok);
        int t;
        t = 0;
        while (tx_o !== 1'b0 && t < 3 * BAUD_DIV + 4) begin
            @(negedge clk);
            t++;
        end
        ok = (tx_o === 1'b0);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic [1:0] p, input logic s2, input string name);
        logic [11:0] eb, ob;
        int          n;
        logic        ok;
        n = build_frame(d, p, s2, eb);
        par_cfg  = p;
        stop_cfg = s2;
        tx_data  = d;
        busy_cnt = 0;
        tx_en    = 1'b1;
        if (rx_sel) exp_q.push_back('{d, 1'b0, 1'b0});
        wait_tx_fall(ok);
        tx_en = 1'b0;
        if (!ok) begin
            check({name, "_start_timeout"}, {31'd0, tx_o}, 32'd0);
            return;
        end
        ob = '1;
        for (int i = 0; i < n; i++) begin
            ob[i] = tx_o;
            repeat (BAUD_DIV) @(negedge clk);
        end
        check(name, {20'd0, ob}, {20'd0, eb});
        check({name, "_busy"}, busy_cnt, 4 * n);
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic inject(input logic [7:0] d, input logic has_par, input logic pb, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(pb);
        drive_bit(stopb);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ob2, eb2;
        logic [11:0] fa, fb;
        logic        ok;
        logic [7:0]  d;
        logic [1:0]  p;
        logic        s, flip, good_pb;
        int          rel, v0;

        rx_en    = 1'b1;
        rx_sel   = 1'b1;
        par_cfg  = 2'b01;
        stop_cfg = 1'b1;
        tx_data  = 8'hDA;
        repeat (3) @(negedge clk);
        check("reset_tx_o", {31'd0, tx_o}, 32'd1);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_perr", {31'd0, rx_perr}, 32'd0);
        check("reset_rx_ferr", {31'd0, rx_ferr}, 32'd0);

        rst_n = 1'b1;
        rel = cyc;
        tx_frame(8'hDA, 2'b01, 1'b1, "tx_da_odd_2stop");
        repeat (12) @(negedge clk);
        check("rx_latency_le56", {31'd0, (n_valid == 1) && (last_valid_cyc - rel <= 56)}, 32'd1);

        tx_frame(8'hDA, 2'b10, 1'b0, "tx_da_even_1stop");
        repeat (4) @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            d = 8'($urandom);
            p = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            tx_frame(d, p, s, "tx_random");
            repeat (2) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        void'(build_frame(8'h55, 2'b00, 1'b0, fa));
        void'(build_frame(8'hA3, 2'b00, 1'b0, fb));
        par_cfg  = 2'b00;
        stop_cfg = 1'b0;
        tx_data  = 8'h55;
        busy_cnt = 0;
        tx_en    = 1'b1;
        exp_q.push_back('{8'h55, 1'b0, 1'b0});
        exp_q.push_back('{8'hA3, 1'b0, 1'b0});
        wait_tx_fall(ok);
        tx_data = 8'hA3;
        ob2 = '1;
        if (!ok) begin
            tx_en = 1'b0;
            check("b2b_start_timeout", {31'd0, tx_o}, 32'd0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                if (i == 10) tx_en = 1'b0;
                ob2[i] = tx_o;
                repeat (BAUD_DIV) @(negedge clk);
            end
            eb2 = {4'hF, fb[9:0], fa[9:0]};
            check("tx_back_to_back", {8'd0, ob2}, {8'd0, eb2});
            check("tx_back_to_back_busy", busy_cnt, 80);
        end
        repeat (20) @(negedge clk);
        check("rx_queue_drained", exp_q.size(), 0);

        rx_sel = 1'b0;
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
        v0 = n_valid;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        check("rx_glitch_no_valid", n_valid, v0);

        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(i % 2));
        rx_en = 1'b0;
        for (int i = 4; i < 8; i++) drive_bit(1'(i % 2));
        drive_bit(1'b0);
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
        rx_en = 1'b1;
        repeat (8) @(negedge clk);
        check("rx_abort_no_valid", n_valid, v0);

        par_cfg = 2'b01;
        exp_q.push_back('{8'hDA, 1'b1, 1'b1});
        inject(8'hDA, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            p = (k % 2 == 0) ? 2'b10 : 2'b01;
            flip = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            good_pb = par_bit(d, p);
            par_cfg = p;
            exp_q.push_back('{d, flip, ~s});
            inject(d, 1'b1, good_pb ^ flip, s);
        end
        repeat (4) @(negedge clk);
        check("rx_inject_drained", exp_q.size(), 0);

        par_cfg = 2'b00;
        tx_data = 8'hFF;
        tx_en   = 1'b1;
        wait_tx_fall(ok);
        tx_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_tx_o", {31'd0, tx_o}, 32'd1);
        check("midframe_reset_busy", {31'd0, tx_busy}, 32'd0);
        check("midframe_reset_rx_data", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
